// File: rtl/uarch_trace_pkg.sv
// Shared types for the pipeline trace encoder: event kinds, per-stage FSM states
// and a width helper used for index-sized fields.
package uarch_trace_pkg;

  typedef enum logic [1:0] {
    SINGLE = 2'd0,
    START  = 2'd1,
    END    = 2'd2,
    ABORT  = 2'd3
  } evt_kind_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } stage_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uarch_trace_fifo.sv
// Event queue: up to PORTS pre-compacted entries written per cycle, one popped.
// Entry i of push_data lands at write pointer + i; the caller never overfills.
module uarch_trace_fifo
  import uarch_trace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PORTS = 2,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = idx_w(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CNT_W-1:0]            push_cnt,
  input  logic [PORTS-1:0][WIDTH-1:0] push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic                        valid,
  output logic [CNT_W-1:0]            count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // DEPTH is a power of two, so the modulo reduces to a plain bit mask.
  function automatic logic [PTR_W-1:0] wrap(input int p);
    return PTR_W'(p % DEPTH);
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (i < int'(push_cnt)) begin
        mem[wrap(int'(wptr) + i)] <= push_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wrap(int'(wptr) + int'(push_cnt));
      if (pop) begin
        rptr <= wrap(int'(rptr) + 1);
      end
      count <= count + push_cnt - CNT_W'(pop);
    end
  end

  assign valid = (count != '0);
  assign head  = valid ? mem[rptr] : '0;

endmodule

// File: rtl/uarch_trace_encoder.sv
// Pipeline trace encoder: per-stage occupancy FSMs classify events, which are
// timestamped, compacted into a shared FIFO and streamed out over valid/ready.
module uarch_trace_encoder
  import uarch_trace_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int PC_W       = 32,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 8,
  localparam int SW        = idx_w(NUM_STAGES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trace_en_i,
  input  logic [NUM_STAGES-1:0]      stage_active_i,
  input  logic [NUM_STAGES-1:0]      stage_done_i,
  input  logic [NUM_STAGES*PC_W-1:0] stage_pc_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [SW-1:0]              evt_stage_o,
  output logic [1:0]                 evt_kind_o,
  output logic [PC_W-1:0]            evt_pc_o,
  output logic [TS_W-1:0]            evt_ts_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = DROP_W + CNT_W;

  typedef struct packed {
    logic [SW-1:0]   stage;
    evt_kind_e       kind;
    logic [PC_W-1:0] pc;
    logic [TS_W-1:0] ts;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  stage_state_e                          state     [NUM_STAGES];
  stage_state_e                          state_nxt [NUM_STAGES];
  evt_kind_e                             kind      [NUM_STAGES];
  logic [NUM_STAGES-1:0]                 emit;
  logic [TS_W-1:0]                       ts;
  logic [DROP_W-1:0]                     drop_cnt;
  logic [DROP_W-1:0]                     drop_nxt;
  logic [SUM_W-1:0]                      drop_sum;
  logic [CNT_W-1:0]                      fifo_count;
  logic [CNT_W-1:0]                      free;
  logic [CNT_W-1:0]                      n_wr;
  logic [CNT_W-1:0]                      n_drop;
  logic [NUM_STAGES-1:0][EVT_W-1:0]      wr_data;
  evt_t                                  cur;
  logic [EVT_W-1:0]                      head_raw;
  evt_t                                  head;
  logic                                  head_valid;
  logic                                  pop;

  always_comb begin
    for (int s = 0; s < NUM_STAGES; s++) begin
      emit[s]      = 1'b0;
      kind[s]      = SINGLE;
      state_nxt[s] = IDLE;
      if (trace_en_i) begin
        case (state[s])
          IDLE: begin
            if (stage_active_i[s]) begin
              emit[s]      = 1'b1;
              kind[s]      = stage_done_i[s] ? SINGLE : START;
              state_nxt[s] = stage_done_i[s] ? IDLE : BUSY;
            end
          end
          BUSY: begin
            if (!stage_active_i[s]) begin
              emit[s] = 1'b1;
              kind[s] = ABORT;
            end else if (stage_done_i[s]) begin
              emit[s] = 1'b1;
              kind[s] = END;
            end else begin
              state_nxt[s] = BUSY;
            end
          end
          default: state_nxt[s] = IDLE;
        endcase
      end
    end
  end

  // Free space is taken before this cycle's pop, so a full FIFO drops even when draining.
  always_comb begin
    free    = CNT_W'(FIFO_DEPTH) - fifo_count;
    n_wr    = '0;
    n_drop  = '0;
    wr_data = '0;
    cur     = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (emit[s]) begin
        cur.stage = SW'(s);
        cur.kind  = kind[s];
        cur.pc    = stage_pc_i[s*PC_W +: PC_W];
        cur.ts    = ts;
        if (n_wr < free) begin
          for (int j = 0; j < NUM_STAGES; j++) begin
            if (CNT_W'(j) == n_wr) begin
              wr_data[j] = cur;
            end
          end
          n_wr = n_wr + CNT_W'(1);
        end else begin
          n_drop = n_drop + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    drop_sum = SUM_W'(drop_cnt) + SUM_W'(n_drop);
    drop_nxt = (drop_sum > SUM_W'({DROP_W{1'b1}})) ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts       <= '0;
      drop_cnt <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        state[s] <= IDLE;
      end
    end else begin
      ts       <= ts + TS_W'(1);
      drop_cnt <= drop_nxt;
      for (int s = 0; s < NUM_STAGES; s++) begin
        state[s] <= state_nxt[s];
      end
    end
  end

  uarch_trace_fifo #(
    .WIDTH (EVT_W),
    .PORTS (NUM_STAGES),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_cnt  (n_wr),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head_raw),
    .valid     (head_valid),
    .count     (fifo_count)
  );

  assign pop         = head_valid & evt_ready_i;
  assign head        = head_raw;
  assign evt_valid_o = head_valid;
  assign evt_stage_o = head.stage;
  assign evt_kind_o  = head.kind;
  assign evt_pc_o    = head.pc;
  assign evt_ts_o    = head.ts;
  assign drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_uarch_trace_encoder.sv
// Bench for uarch_trace_encoder: a wide instance and a narrow (TS_W=4, DROP_W=3)
// instance share one stimulus stream and one queue-based event model.
module tb_uarch_trace_encoder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trace_en = 1'b0;
  logic [1:0]  active = '0;
  logic [1:0]  done = '0;
  logic [63:0] pcs = '0;
  logic        ready = 1'b0;

  logic        a_valid;
  logic        a_stage;
  logic [1:0]  a_kind;
  logic [31:0] a_pc;
  logic [15:0] a_ts;
  logic [7:0]  a_drop;

  logic        b_valid;
  logic        b_stage;
  logic [1:0]  b_kind;
  logic [31:0] b_pc;
  logic [3:0]  b_ts;
  logic [2:0]  b_drop;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uarch_trace_encoder #(
    .NUM_STAGES (2), .PC_W (32), .TS_W (16), .FIFO_DEPTH (DEPTH), .DROP_W (8)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .trace_en_i (trace_en),
    .stage_active_i (active), .stage_done_i (done), .stage_pc_i (pcs),
    .evt_valid_o (a_valid), .evt_ready_i (ready), .evt_stage_o (a_stage),
    .evt_kind_o (a_kind), .evt_pc_o (a_pc), .evt_ts_o (a_ts), .drop_cnt_o (a_drop)
  );

  uarch_trace_encoder #(
    .NUM_STAGES (2), .PC_W (32), .TS_W (4), .FIFO_DEPTH (DEPTH), .DROP_W (3)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .trace_en_i (trace_en),
    .stage_active_i (active), .stage_done_i (done), .stage_pc_i (pcs),
    .evt_valid_o (b_valid), .evt_ready_i (ready), .evt_stage_o (b_stage),
    .evt_kind_o (b_kind), .evt_pc_o (b_pc), .evt_ts_o (b_ts), .drop_cnt_o (b_drop)
  );

  // Reference model: events as a plain queue, one busy flag per stage.
  typedef struct {
    int          stage;
    int          kind;
    logic [31:0] pc;
    logic [15:0] ts;
  } mevt_t;

  mevt_t       q[$];
  int          m_drop = 0;
  logic [15:0] m_ts = '0;
  bit   [1:0]  m_busy = '0;
  int          space;
  bit          emit;
  mevt_t       e;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_drop = 0;
      m_ts   = '0;
      m_busy = '0;
    end else begin
      space = DEPTH - q.size();
      if (q.size() != 0 && ready) void'(q.pop_front());
      for (int s = 0; s < 2; s++) begin
        emit = 1'b0;
        e.kind = 0;
        if (!trace_en) begin
          m_busy[s] = 1'b0;
        end else if (!m_busy[s]) begin
          if (active[s]) begin
            emit = 1'b1;
            e.kind = done[s] ? 0 : 1;
            m_busy[s] = !done[s];
          end
        end else if (!active[s]) begin
          emit = 1'b1;
          e.kind = 3;
          m_busy[s] = 1'b0;
        end else if (done[s]) begin
          emit = 1'b1;
          e.kind = 2;
          m_busy[s] = 1'b0;
        end
        if (emit) begin
          e.stage = s;
          e.pc    = pcs[s*32 +: 32];
          e.ts    = m_ts;
          if (space > 0) begin
            q.push_back(e);
            space--;
          end else begin
            m_drop++;
          end
        end
      end
      m_ts = m_ts + 16'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus hold-while-stalled check.
  logic [51:0] prev_out;
  bit          prev_stall = 1'b0;
  logic [51:0] cur_out;

  always @(negedge clk) begin
    checkOutput("valid_a", a_valid, q.size() != 0);
    checkOutput("valid_b", b_valid, q.size() != 0);
    if (q.size() != 0) begin
      checkOutput("stage_a", a_stage, q[0].stage);
      checkOutput("kind_a", a_kind, q[0].kind);
      checkOutput("pc_a", a_pc, q[0].pc);
      checkOutput("ts_a", a_ts, q[0].ts);
      checkOutput("stage_b", b_stage, q[0].stage);
      checkOutput("kind_b", b_kind, q[0].kind);
      checkOutput("pc_b", b_pc, q[0].pc);
      checkOutput("ts_b", b_ts, q[0].ts[3:0]);
    end
    checkOutput("drop_a", a_drop, (m_drop > 255) ? 255 : m_drop);
    checkOutput("drop_b", b_drop, (m_drop > 7) ? 7 : m_drop);
    cur_out = {a_valid, a_stage, a_kind, a_pc, a_ts};
    if (prev_stall) checkOutput("hold_a", cur_out, prev_out);
    prev_out   = cur_out;
    prev_stall = rst_n && a_valid && !ready;
  end

  task automatic applyStimulus(input logic [1:0] act, input logic [1:0] dn,
                               input logic [31:0] p0, input logic [31:0] p1,
                               input logic en, input logic rdy);
    active   = act;
    done     = dn;
    pcs      = {p1, p0};
    trace_en = en;
    ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idleUntil(input int target);
    int guard = 0;
    while (int'(m_ts) != target && guard < 200) begin
      applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
      guard++;
    end
    checkOutput("ts_sync", m_ts, target);
  endtask

  task automatic checkHead(input string name, input logic st, input logic [1:0] kd,
                           input logic [31:0] pc, input logic [15:0] ts);
    checkOutput({name, "_valid"}, a_valid, 1'b1);
    checkOutput({name, "_stage"}, a_stage, st);
    checkOutput({name, "_kind"}, a_kind, kd);
    checkOutput({name, "_pc"}, a_pc, pc);
    checkOutput({name, "_ts"}, a_ts, ts);
  endtask

  initial begin
    rst_n = 1'b0;
    trace_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", a_valid, 1'b0);
    checkOutput("rst_stage", a_stage, 1'b0);
    checkOutput("rst_kind", a_kind, 2'd0);
    checkOutput("rst_pc", a_pc, 32'h0);
    checkOutput("rst_ts", a_ts, 16'h0);
    checkOutput("rst_drop_a", a_drop, 8'd0);
    checkOutput("rst_drop_b", b_drop, 3'd0);
    rst_n = 1'b1;

    // Single-cycle occupancy
    idleUntil(5);
    applyStimulus(2'b01, 2'b01, 32'h100, 32'h0, 1'b1, 1'b1);
    checkHead("single", 1'b0, 2'd0, 32'h100, 16'd5);

    // Multicycle occupancy on stage 1
    idleUntil(10);
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h200, 1'b1, 1'b1);
    checkHead("start", 1'b1, 2'd1, 32'h200, 16'd10);
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h200, 1'b1, 1'b1);
    checkOutput("mid1_valid", a_valid, 1'b0);
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h200, 1'b1, 1'b1);
    checkOutput("mid2_valid", a_valid, 1'b0);
    applyStimulus(2'b10, 2'b10, 32'h0, 32'h200, 1'b1, 1'b1);
    checkHead("end", 1'b1, 2'd2, 32'h200, 16'd13);

    // Flush while busy, then FSM is idle again
    idleUntil(20);
    applyStimulus(2'b01, 2'b00, 32'h300, 32'h0, 1'b1, 1'b1);
    applyStimulus(2'b01, 2'b00, 32'h300, 32'h0, 1'b1, 1'b1);
    applyStimulus(2'b00, 2'b00, 32'h300, 32'h0, 1'b1, 1'b1);
    checkHead("abort", 1'b0, 2'd3, 32'h300, 16'd22);
    applyStimulus(2'b01, 2'b01, 32'h304, 32'h0, 1'b1, 1'b1);
    checkHead("post_abort", 1'b0, 2'd0, 32'h304, 16'd23);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1);

    // Overflow with the sink stalled
    repeat (6) applyStimulus(2'b11, 2'b11, 32'h400, 32'h404, 1'b1, 1'b0);
    checkHead("ovf_head", 1'b0, 2'd0, 32'h400, 16'd25);
    checkOutput("ovf_drop4", a_drop, 8'd4);
    applyStimulus(2'b11, 2'b11, 32'h400, 32'h404, 1'b1, 1'b0);
    checkOutput("ovf_drop6", a_drop, 8'd6);
    repeat (3) applyStimulus(2'b11, 2'b11, 32'h400, 32'h404, 1'b1, 1'b0);
    checkOutput("ovf_drop12", a_drop, 8'd12);
    checkOutput("ovf_sat_b", b_drop, 3'd7);
    applyStimulus(2'b11, 2'b11, 32'h400, 32'h404, 1'b1, 1'b1);
    checkOutput("full_pop_drop", a_drop, 8'd14);

    // Reset with entries still queued
    repeat (4) applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    checkOutput("pre_rst_valid", a_valid, 1'b1);
    rst_n = 1'b0;
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("mid_rst_valid", a_valid, 1'b0);
    checkOutput("mid_rst_drop_a", a_drop, 8'd0);
    checkOutput("mid_rst_drop_b", b_drop, 3'd0);
    rst_n = 1'b1;

    // Disable while busy: no event, and re-entry reports SINGLE
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h500, 1'b1, 1'b1);
    checkHead("en_start", 1'b1, 2'd1, 32'h500, 16'd0);
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h500, 1'b0, 1'b1);
    checkOutput("dis1_valid", a_valid, 1'b0);
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h500, 1'b0, 1'b1);
    checkOutput("dis2_valid", a_valid, 1'b0);
    applyStimulus(2'b10, 2'b10, 32'h0, 32'h504, 1'b1, 1'b1);
    checkHead("reen", 1'b1, 2'd0, 32'h504, 16'd3);

    // Timestamp wrap on the narrow instance
    idleUntil(15);
    applyStimulus(2'b01, 2'b01, 32'hA0, 32'h0, 1'b1, 1'b0);
    checkOutput("wrap15_a", a_ts, 16'd15);
    checkOutput("wrap15_b", b_ts, 4'd15);
    applyStimulus(2'b01, 2'b01, 32'hA4, 32'h0, 1'b1, 1'b1);
    checkOutput("wrap16_a", a_ts, 16'd16);
    checkOutput("wrap16_b", b_ts, 4'd0);
    checkOutput("wrap16_pc", b_pc, 32'hA4);

    // Random traffic with random backpressure
    repeat (120) begin
      applyStimulus(2'($urandom), 2'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 9) != 0), 1'($urandom));
    end
    repeat (20) applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    checkOutput("final_empty", a_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
